alu_operand_stage: RTL and testbench

// - Decode/execute boundary register feeding the 16-bit ALU: holds one decoded op, drives ALU A/B/OP.
// - Resolves RAW hazards by forwarding from EX/MEM and MEM/WB write-back buses, selects immediate operand.
// - Single-entry valid/ready stage with stall hold and flush; sits directly upstream of the ALU.

---
 rtl/alu_operand_stage.sv | 195 +++++++++++++++++++
 tb/tb_alu_operand_stage.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// alu_operand_stage
// Decode/execute boundary register in front of the ALU. Holds one decoded op
// and drives the ALU A/B/OP inputs. RAW hazards are resolved by forwarding from
// the EX/MEM bus (fw1, higher priority) and the MEM/WB bus (fw2). Operand B can
// instead come from the sign- or zero-extended 8-bit immediate.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready          upstream handshake; in_ready = empty | out_ready
//   in_op                      ALU opcode, passed through unmodified
//   in_rs1_idx/in_rs2_idx      source register indices
//   in_rs1_val/in_rs2_val      register-file read values
//   in_imm8, in_b_sel          immediate and B-source select
//   in_rd_idx, in_rd_we        destination index and write enable
//   fw1_*, fw2_*               forwarding buses (fw1 newer, wins over fw2)
//   flush                      drop held op and any incoming op
//   out_valid/out_ready        downstream handshake
//   alu_a, alu_b, alu_op       registered ALU inputs
//   out_rd_idx, out_rd_we      destination passed down; we is 0 when not valid

module alu_operand_stage #(
    parameter int unsigned DW = 16,
    parameter int unsigned RW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [RW-1:0] in_rs1_idx,
    input  logic [RW-1:0] in_rs2_idx,
    input  logic [DW-1:0] in_rs1_val,
    input  logic [DW-1:0] in_rs2_val,
    input  logic [7:0]    in_imm8,
    input  logic [1:0]    in_b_sel,
    input  logic [RW-1:0] in_rd_idx,
    input  logic          in_rd_we,
    input  logic          fw1_we,
    input  logic [RW-1:0] fw1_idx,
    input  logic [DW-1:0] fw1_val,
    input  logic          fw2_we,
    input  logic [RW-1:0] fw2_idx,
    input  logic [DW-1:0] fw2_val,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_op,
    output logic [RW-1:0] out_rd_idx,
    output logic          out_rd_we
);

    // Holding registers
    logic          r_full;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [3:0]    r_op;
    logic [RW-1:0] r_rd_idx;
    logic          r_rd_we;
    logic [RW-1:0] r_rs1_idx;
    logic [RW-1:0] r_rs2_idx;
    logic          r_b_imm;   // B came from the immediate: never forwarded over

    // Next-state
    logic          w_full_d;
    logic [DW-1:0] w_a_d;
    logic [DW-1:0] w_b_d;
    logic [3:0]    w_op_d;
    logic [RW-1:0] w_rd_idx_d;
    logic          w_rd_we_d;
    logic [RW-1:0] w_rs1_idx_d;
    logic [RW-1:0] w_rs2_idx_d;
    logic          w_b_imm_d;

    logic          w_in_ready;
    logic          w_capture;
    logic          w_stall;

    // Forward mux: fw1 (EX/MEM) beats fw2 (MEM/WB) beats the current value.
    function automatic logic [DW-1:0] fwd_sel(
        input logic [RW-1:0] idx,
        input logic [DW-1:0] cur,
        input logic          f1_we,
        input logic [RW-1:0] f1_idx,
        input logic [DW-1:0] f1_val,
        input logic          f2_we,
        input logic [RW-1:0] f2_idx,
        input logic [DW-1:0] f2_val
    );
        logic [DW-1:0] res;
        res = cur;
        if (f1_we && (f1_idx == idx)) begin
            res = f1_val;
        end else if (f2_we && (f2_idx == idx)) begin
            res = f2_val;
        end
        return res;
    endfunction

    always_comb begin
        w_in_ready = ~r_full | out_ready;
        w_capture  = in_valid & w_in_ready & ~flush;
        w_stall    = r_full & ~out_ready;

        w_full_d    = r_full;
        w_a_d       = r_a;
        w_b_d       = r_b;
        w_op_d      = r_op;
        w_rd_idx_d  = r_rd_idx;
        w_rd_we_d   = r_rd_we;
        w_rs1_idx_d = r_rs1_idx;
        w_rs2_idx_d = r_rs2_idx;
        w_b_imm_d   = r_b_imm;

        if (flush) begin
            w_full_d = 1'b0;
        end else if (w_capture) begin
            w_full_d = 1'b1;
        end else if (out_ready) begin
            w_full_d = 1'b0;
        end

        if (w_capture) begin
            w_op_d      = in_op;
            w_rd_idx_d  = in_rd_idx;
            w_rd_we_d   = in_rd_we;
            w_rs1_idx_d = in_rs1_idx;
            w_rs2_idx_d = in_rs2_idx;
            w_a_d       = fwd_sel(in_rs1_idx, in_rs1_val, fw1_we, fw1_idx, fw1_val,
                                  fw2_we, fw2_idx, fw2_val);
            case (in_b_sel)
                2'b01: begin
                    w_b_d     = {{(DW-8){in_imm8[7]}}, in_imm8};
                    w_b_imm_d = 1'b1;
                end
                2'b10: begin
                    w_b_d     = {{(DW-8){1'b0}}, in_imm8};
                    w_b_imm_d = 1'b1;
                end
                default: begin
                    // 2'b11 is reserved and behaves as rs2
                    w_b_d     = fwd_sel(in_rs2_idx, in_rs2_val, fw1_we, fw1_idx, fw1_val,
                                        fw2_we, fw2_idx, fw2_val);
                    w_b_imm_d = 1'b0;
                end
            endcase
        end else if (w_stall) begin
            // Held op keeps picking up results that retire while it waits,
            // matched against the indices latched with the op.
            w_a_d = fwd_sel(r_rs1_idx, r_a, fw1_we, fw1_idx, fw1_val,
                            fw2_we, fw2_idx, fw2_val);
            if (!r_b_imm) begin
                w_b_d = fwd_sel(r_rs2_idx, r_b, fw1_we, fw1_idx, fw1_val,
                                fw2_we, fw2_idx, fw2_val);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_full    <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= '0;
            r_rd_idx  <= '0;
            r_rd_we   <= 1'b0;
            r_rs1_idx <= '0;
            r_rs2_idx <= '0;
            r_b_imm   <= 1'b0;
        end else begin
            r_full    <= w_full_d;
            r_a       <= w_a_d;
            r_b       <= w_b_d;
            r_op      <= w_op_d;
            r_rd_idx  <= w_rd_idx_d;
            r_rd_we   <= w_rd_we_d;
            r_rs1_idx <= w_rs1_idx_d;
            r_rs2_idx <= w_rs2_idx_d;
            r_b_imm   <= w_b_imm_d;
        end
    end

    always_comb begin
        in_ready   = w_in_ready;
        out_valid  = r_full;
        alu_a      = r_a;
        alu_b      = r_b;
        alu_op     = r_op;
        out_rd_idx = r_rd_idx;
        // Downstream must never see a write from an empty slot
        out_rd_we  = r_full & r_rd_we;
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: stimulus pushes hand-computed expected
// ALU inputs at acceptance; a monitor pops and compares on every output handshake.

module tb_alu_operand_stage;

    localparam int unsigned DW = 16;
    localparam int unsigned RW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [RW-1:0] in_rs1_idx;
    logic [RW-1:0] in_rs2_idx;
    logic [DW-1:0] in_rs1_val;
    logic [DW-1:0] in_rs2_val;
    logic [7:0]    in_imm8;
    logic [1:0]    in_b_sel;
    logic [RW-1:0] in_rd_idx;
    logic          in_rd_we;
    logic          fw1_we;
    logic [RW-1:0] fw1_idx;
    logic [DW-1:0] fw1_val;
    logic          fw2_we;
    logic [RW-1:0] fw2_idx;
    logic [DW-1:0] fw2_val;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [3:0]    alu_op;
    logic [RW-1:0] out_rd_idx;
    logic          out_rd_we;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [3:0]    op;
        logic [RW-1:0] rd;
        logic          we;
    } exp_t;

    exp_t exp_q[$];
    exp_t drop;
    int   n_cmp = 0;
    int   n_err = 0;

    alu_operand_stage #(.DW(DW), .RW(RW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs1_idx (in_rs1_idx),
        .in_rs2_idx (in_rs2_idx),
        .in_rs1_val (in_rs1_val),
        .in_rs2_val (in_rs2_val),
        .in_imm8    (in_imm8),
        .in_b_sel   (in_b_sel),
        .in_rd_idx  (in_rd_idx),
        .in_rd_we   (in_rd_we),
        .fw1_we     (fw1_we),
        .fw1_idx    (fw1_idx),
        .fw1_val    (fw1_val),
        .fw2_we     (fw2_we),
        .fw2_idx    (fw2_idx),
        .fw2_val    (fw2_val),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .out_rd_idx (out_rd_idx),
        .out_rd_we  (out_rd_we)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake must match the oldest expected op
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got op %0h, expected no output", alu_op);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_alu_a", 32'(alu_a), 32'(e.a));
                check("sb_alu_b", 32'(alu_b), 32'(e.b));
                check("sb_alu_op", 32'(alu_op), 32'(e.op));
                check("sb_rd_idx", 32'(out_rd_idx), 32'(e.rd));
                check("sb_rd_we", 32'(out_rd_we), 32'(e.we));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_fw();
        fw1_we = 1'b0; fw1_idx = '0; fw1_val = '0;
        fw2_we = 1'b0; fw2_idx = '0; fw2_val = '0;
    endtask

    // Presents one op (forward buses set by caller beforehand), waits for
    // acceptance, pushes the expected result, then clears in_valid and fw buses.
    task automatic send(input logic [3:0] op, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                        input logic [DW-1:0] v1, input logic [DW-1:0] v2, input logic [7:0] imm,
                        input logic [1:0] bsel, input logic [RW-1:0] rd, input logic we,
                        input logic [DW-1:0] ea, input logic [DW-1:0] eb);
        logic ok;
        exp_t e;
        in_op = op; in_rs1_idx = rs1; in_rs2_idx = rs2; in_rs1_val = v1; in_rs2_val = v2;
        in_imm8 = imm; in_b_sel = bsel; in_rd_idx = rd; in_rd_we = we;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("accept", 32'(ok), 32'd1);
        if (ok) begin
            e.a = ea; e.b = eb; e.op = op; e.rd = rd; e.we = we;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear_fw();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_op = '0; in_rs1_idx = '0; in_rs2_idx = '0;
        in_rs1_val = '0; in_rs2_val = '0; in_imm8 = '0; in_b_sel = '0; in_rd_idx = '0;
        in_rd_we = 1'b0; flush = 1'b0; out_ready = 1'b1;
        clear_fw();

        // Reset state
        idle(2);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_rd_we", 32'(out_rd_we), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Forward priority: fw1 beats fw2 on same index
        fw1_we = 1'b1; fw1_idx = 2'd2; fw1_val = 16'h00AA;
        fw2_we = 1'b1; fw2_idx = 2'd2; fw2_val = 16'h00BB;
        send(4'd5, 2'd2, 2'd1, 16'h0001, 16'h0011, 8'h00, 2'b00, 2'd3, 1'b1,
             16'h00AA, 16'h0011);
        // fw2 alone on rs1, fw1 on rs2
        fw1_we = 1'b1; fw1_idx = 2'd2; fw1_val = 16'h00AA;
        fw2_we = 1'b1; fw2_idx = 2'd1; fw2_val = 16'h00BB;
        send(4'd6, 2'd1, 2'd2, 16'h0101, 16'h0202, 8'h00, 2'b00, 2'd0, 1'b0,
             16'h00BB, 16'h00AA);
        idle(2);

        // Stall refresh of register-sourced B
        out_ready = 1'b0;
        send(4'd7, 2'd0, 2'd3, 16'h1000, 16'h2222, 8'h00, 2'b00, 2'd1, 1'b1,
             16'h1000, 16'h7777);
        fw2_we = 1'b1; fw2_idx = 2'd3; fw2_val = 16'h7777;
        idle(1);
        clear_fw();
        @(negedge clk);
        check("stall_alu_b", 32'(alu_b), 32'h7777);
        check("stall_alu_op", 32'(alu_op), 32'd7);
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(2);

        // Immediates
        fw1_we = 1'b1; fw1_idx = 2'd2; fw1_val = 16'h1111;
        send(4'd8, 2'd0, 2'd2, 16'h0009, 16'h5555, 8'h80, 2'b01, 2'd2, 1'b1,
             16'h0009, 16'hFF80);
        fw2_we = 1'b1; fw2_idx = 2'd2; fw2_val = 16'h2222;
        send(4'd9, 2'd2, 2'd2, 16'h0002, 16'h5555, 8'h80, 2'b10, 2'd3, 1'b0,
             16'h2222, 16'h0080);
        idle(2);
        // Stalled immediate: A refreshes, B stays the immediate
        out_ready = 1'b0;
        send(4'd10, 2'd1, 2'd1, 16'h0003, 16'h4444, 8'h7F, 2'b01, 2'd1, 1'b1,
             16'hDEAD, 16'h007F);
        fw1_we = 1'b1; fw1_idx = 2'd1; fw1_val = 16'hDEAD;
        idle(1);
        clear_fw();
        @(negedge clk);
        check("imm_hold_b", 32'(alu_b), 32'h007F);
        check("imm_refresh_a", 32'(alu_a), 32'hDEAD);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        // Reserved b_sel behaves as rs2
        fw1_we = 1'b1; fw1_idx = 2'd3; fw1_val = 16'h9999;
        send(4'd11, 2'd3, 2'd0, 16'h0033, 16'h4321, 8'hFF, 2'b11, 2'd0, 1'b1,
             16'h9999, 16'h4321);
        idle(2);

        // Back-to-back, no bubble
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            in_op = 4'(i); in_rs1_idx = 2'(i); in_rs2_idx = 2'(i);
            in_rs1_val = 16'h0100 + 16'(i); in_rs2_val = 16'h0200 + 16'(i);
            in_imm8 = 8'h00; in_b_sel = 2'b00; in_rd_idx = 2'(i); in_rd_we = 1'(i);
            in_valid = 1'b1;
            e.a = 16'h0100 + 16'(i); e.b = 16'h0200 + 16'(i); e.op = 4'(i);
            e.rd = 2'(i); e.we = 1'(i);
            exp_q.push_back(e);
            @(negedge clk);
            check("b2b_in_ready", 32'(in_ready), 32'd1);
            if (i > 0) begin
                check("b2b_valid", 32'(out_valid), 32'd1);
                check("b2b_op", 32'(alu_op), 32'(i - 1));
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_last_op", 32'(alu_op), 32'd3);
        @(posedge clk);
        #1;
        idle(1);

        // Flush with incoming op
        out_ready = 1'b0;
        send(4'd12, 2'd0, 2'd0, 16'h00C0, 16'h00C1, 8'h00, 2'b00, 2'd2, 1'b1,
             16'h00C0, 16'h00C1);
        in_op = 4'd13; in_rd_we = 1'b1; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        drop = exp_q.pop_back();
        @(negedge clk);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_rd_we", 32'(out_rd_we), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(2);
        @(negedge clk);
        check("flush_stays_empty", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Reset mid-op
        out_ready = 1'b0;
        send(4'd3, 2'd0, 2'd0, 16'h1234, 16'h5678, 8'h00, 2'b00, 2'd2, 1'b1,
             16'h1234, 16'h5678);
        @(negedge clk);
        check("pre_reset_a", 32'(alu_a), 32'h1234);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        drop = exp_q.pop_back();
        @(negedge clk);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_a", 32'(alu_a), 32'd0);
        check("mid_rst_b", 32'(alu_b), 32'd0);
        check("mid_rst_op", 32'(alu_op), 32'd0);
        check("mid_rst_rd_we", 32'(out_rd_we), 32'd0);
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        idle(3);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
